// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the scanned 4x4 keypad reader.
//   NUM_ROWS / NUM_COLS / CODE_W : matrix geometry and key code width
//   frame_kind_e                 : classification of one complete scan frame
//   key_state_e                  : acceptance FSM states
//   frame_t                      : frame kind plus key code (code = row*4+col)
//   classify_frame()             : turns a 16-bit pressed map into a frame_t
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int CODE_W   = 4;
   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } frame_kind_e;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } key_state_e;

   typedef struct packed {
      frame_kind_e        kind;
      logic [CODE_W-1:0]  code;
   } frame_t;

   // pressed[i] is high when key code i was seen closed during the frame.
   // The code field is forced to zero for NONE and MULTI so that frame
   // comparisons in the debouncer only ever depend on meaningful bits.
   function automatic frame_t classify_frame(input logic [NUM_KEYS-1:0] pressed);
      frame_t     f;
      logic [1:0] hits;
      logic [CODE_W-1:0] first_code;
      hits       = 2'd0;
      first_code = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (pressed[i]) begin
            if (hits == 2'd0) first_code = CODE_W'(i);
            if (hits != 2'd2) hits = hits + 2'd1;
         end
      end
      case (hits)
         2'd0:    begin f.kind = NONE;   f.code = '0;         end
         2'd1:    begin f.kind = SINGLE; f.code = first_code; end
         default: begin f.kind = MULTI;  f.code = '0;         end
      endcase
      return f;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Frame-level debouncer and press/release FSM for the keypad reader.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of a held key).
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   frame_valid  : one-cycle strobe, frame_in holds a fresh frame result
//   frame_in     : classified frame (NONE / SINGLE(code) / MULTI)
//   key_valid    : one-cycle pulse on an accepted press, roll-over or repeat
//   key_code     : code of the last accepted key, held between events
//   key_held     : high while the accepted key stays stably pressed
// -----------------------------------------------------------------------------
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE      = 3,   // 1..15 identical frames to accept
   parameter int REPEAT_FRAMES = 8    // frames between auto-repeat pulses
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              frame_valid,
   input  frame_t            frame_in,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_code,
   output logic              key_held
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE);

   frame_t            cand_reg, cand_next;
   logic [3:0]        cnt_reg, cnt_next;
   key_state_e        state_reg;
   logic              key_valid_reg;
   logic [CODE_W-1:0] key_code_reg;
   logic              key_held_reg;
   logic              stable;
   logic              accepted;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 1);
   logic [7:0] rep_cnt_reg;
`endif

   // Candidate tracking. A MULTI frame wipes the candidate so the next
   // clean frame has to earn a full DEBOUNCE run from scratch.
   always_comb begin
      cand_next = cand_reg;
      cnt_next  = cnt_reg;
      if (frame_in.kind == MULTI) begin
         cand_next.kind = NONE;
         cand_next.code = '0;
         cnt_next       = 4'd0;
      end else if (frame_in == cand_reg) begin
         if (cnt_reg != DEB) cnt_next = cnt_reg + 4'd1;
      end else begin
         cand_next = frame_in;
         cnt_next  = 4'd1;
      end
   end

   // stable: the counter was already saturated on this same frame, so this
   // frame is not a new arrival at DEBOUNCE and must not re-trigger.
   assign stable   = (frame_in == cand_reg) && (cnt_reg == DEB);
   assign accepted = (frame_in.kind != MULTI) && (cnt_next == DEB) && !stable;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cand_reg.kind <= NONE;
         cand_reg.code <= '0;
         cnt_reg       <= 4'd0;
         state_reg     <= IDLE;
         key_valid_reg <= 1'b0;
         key_code_reg  <= '0;
         key_held_reg  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_reg   <= 8'd0;
`endif
      end else begin
         key_valid_reg <= 1'b0;
         if (frame_valid) begin
            cand_reg <= cand_next;
            cnt_reg  <= cnt_next;
`ifdef KEYPAD_REPEAT_EN
            // Anything other than a stable repeat frame restarts the count.
            rep_cnt_reg <= 8'd0;
`endif
            case (state_reg)
               IDLE: begin
                  if (accepted && frame_in.kind == SINGLE) begin
                     key_valid_reg <= 1'b1;
                     key_code_reg  <= frame_in.code;
                     key_held_reg  <= 1'b1;
                     state_reg     <= HELD;
                  end
               end
               HELD: begin
                  if (accepted && frame_in.kind == NONE) begin
                     key_held_reg <= 1'b0;
                     state_reg    <= IDLE;
                  end else if (accepted && frame_in.kind == SINGLE &&
                               frame_in.code != key_code_reg) begin
                     // Roll-over to a different key without a release.
                     key_valid_reg <= 1'b1;
                     key_code_reg  <= frame_in.code;
                  end
`ifdef KEYPAD_REPEAT_EN
                  else if (stable && frame_in.kind == SINGLE &&
                           frame_in.code == key_code_reg) begin
                     if (rep_cnt_reg == REP_LAST) begin
                        key_valid_reg <= 1'b1;
                     end else begin
                        rep_cnt_reg <= rep_cnt_reg + 8'd1;
                     end
                  end
`endif
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign key_valid = key_valid_reg;
   assign key_code  = key_code_reg;
   assign key_held  = key_held_reg;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// Scanned 4x4 matrix keypad reader. Drives one active-low column per scan_en
// step, samples synchronized active-low rows, classifies each 4-column frame
// and hands it to keypad_debounce for press/release acceptance.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat, see keypad_debounce).
// Ports:
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   scan_en    : one-cycle column-step strobe (>= 3 clk apart)
//   row_in     : keypad rows, active-low, asynchronous
//   col_out    : column drive, active-low one-hot
//   key_valid  : one-cycle pulse on accepted press (or repeat)
//   key_code   : row*4+col of last accepted key
//   key_held   : high while an accepted key remains stably pressed
// -----------------------------------------------------------------------------
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE      = 3,
   parameter int REPEAT_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       scan_en,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   logic [NUM_ROWS-1:0]                 row_meta_reg;
   logic [NUM_ROWS-1:0]                 row_sync_reg;
   logic [1:0]                          col_reg;
   logic [NUM_COLS-2:0][NUM_ROWS-1:0]   rows_lat_reg;
   logic [NUM_COLS-1:0][NUM_ROWS-1:0]   frame_rows;
   logic [NUM_KEYS-1:0]                 pressed;
   logic                                frame_end;
   logic                                frame_valid_reg;
   frame_t                              frame_reg;

   // Two-flop synchronizer; idle level is all rows released.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_meta_reg <= '1;
         row_sync_reg <= '1;
      end else begin
         row_meta_reg <= row_in;
         row_sync_reg <= row_meta_reg;
      end
   end

   // Column counter; the 2-bit add wraps 3 -> 0 on its own.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_reg <= 2'd0;
      end else if (scan_en) begin
         col_reg <= col_reg + 2'd1;
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
         assign col_out[gi] = (col_reg != 2'(gi));
      end

      // Columns 0..2 are latched as they are scanned. Column 3 is never
      // stored: its rows are taken straight from the synchronizer on the
      // frame-completing strobe.
      for (gi = 0; gi < NUM_COLS - 1; gi++) begin : g_row_latch
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               rows_lat_reg[gi] <= '1;
            end else if (scan_en && col_reg == 2'(gi)) begin
               rows_lat_reg[gi] <= row_sync_reg;
            end
         end
      end

      for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         for (gj = 0; gj < NUM_COLS; gj++) begin : g_col
            assign pressed[gi*NUM_COLS + gj] = ~frame_rows[gj][gi];
         end
      end
   endgenerate

   assign frame_rows = {row_sync_reg, rows_lat_reg};
   assign frame_end  = scan_en && (col_reg == 2'(NUM_COLS - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_valid_reg <= 1'b0;
         frame_reg.kind  <= NONE;
         frame_reg.code  <= '0;
      end else begin
         frame_valid_reg <= frame_end;
         if (frame_end) frame_reg <= classify_frame(pressed);
      end
   end

   keypad_debounce #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_FRAMES (REPEAT_FRAMES)
   ) u_debounce (
      .clk         (clk),
      .rstn        (rstn),
      .frame_valid (frame_valid_reg),
      .frame_in    (frame_reg),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_held    (key_held)
   );

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Self-checking bench for keypad_scan. A physical keypad model pulls rows low
// for closed keys on the driven column; a frame-level reference model tracks
// run lengths of identical frames and derives the expected events.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int DEBOUNCE      = 3;
   localparam int REPEAT_FRAMES = 8;

   logic       clk;
   logic       rstn;
   logic       scan_en;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   logic [15:0] keys;      // closed keys, bit index = row*4+col

   int n_tests;
   int n_fail;
   int frame_no;
   int pulses_seen;

   // reference model state: 16 = no key, 17 = several keys
   int         m_run_key;
   int         m_run_len;
   logic       m_held;
   logic [3:0] m_code;
   logic       exp_pulse;

   keypad_scan #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_FRAMES (REPEAT_FRAMES)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .scan_en   (scan_en),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a closed key shorts its row to its column when driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
   end

   function automatic int classify(input logic [15:0] m);
      int n, k;
      n = 0;
      k = 16;
      for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = i; end
      if (n == 0) return 16;
      if (n == 1) return k;
      return 17;
   endfunction

   task automatic model_reset();
      m_run_key = 16;
      m_run_len = 0;
      m_held    = 1'b0;
      m_code    = 4'd0;
      exp_pulse = 1'b0;
   endtask

   task automatic model_frame(input logic [15:0] m);
      int f;
      f = classify(m);
      exp_pulse = 1'b0;
      if (f == 17) begin
         m_run_key = 16;
         m_run_len = 0;
      end else begin
         if (f == m_run_key) m_run_len++;
         else begin m_run_key = f; m_run_len = 1; end
         if (m_run_len == DEBOUNCE) begin
            if (f < 16 && (!m_held || 4'(f) != m_code)) begin
               exp_pulse = 1'b1;
               m_code    = 4'(f);
               m_held    = 1'b1;
            end else if (f == 16 && m_held) begin
               m_held = 1'b0;
            end
         end
`ifdef KEYPAD_REPEAT_EN
         else if (m_held && f < 16 && 4'(f) == m_code && m_run_len > DEBOUNCE &&
                  ((m_run_len - DEBOUNCE) % REPEAT_FRAMES) == 0) begin
            exp_pulse = 1'b1;
         end
`endif
      end
   endtask

   // One scan frame with the given keys closed; checks the event cycle that
   // follows the frame-completing strobe and that no stray pulses appear.
   task automatic run_frame(input logic [15:0] mask);
      int         extra;
      int         idle;
      logic [3:0] exp_col;
      logic [3:0] one4;
      one4  = 4'b0001;
      extra = 0;
      keys  = mask;
      for (int c = 0; c < 4; c++) begin
         idle = $urandom_range(2, 4);
         for (int k = 0; k < idle; k++) begin
            @(posedge clk); #1;
            if (key_valid) extra++;
         end
         exp_col = ~(one4 << c);
         n_tests++;
         if (col_out !== exp_col) begin
            n_fail++;
            $display("FAIL col_out frame %0d col %0d: got %b want %b", frame_no, c, col_out, exp_col);
         end
         scan_en = 1'b1;
         @(posedge clk); #1;
         scan_en = 1'b0;
         if (key_valid) extra++;
      end
      model_frame(mask);
      @(posedge clk); #1;
      if (key_valid) pulses_seen++;
      n_tests++;
      if (key_valid !== exp_pulse) begin
         n_fail++;
         $display("FAIL key_valid frame %0d: got %b want %b", frame_no, key_valid, exp_pulse);
      end
      n_tests++;
      if (key_code !== m_code || key_held !== m_held) begin
         n_fail++;
         $display("FAIL code_held frame %0d: got code %0d held %b want code %0d held %b",
                  frame_no, key_code, key_held, m_code, m_held);
      end
      n_tests++;
      if (extra !== 0) begin
         n_fail++;
         $display("FAIL stray_pulse frame %0d: got %0d extra pulses want 0", frame_no, extra);
      end
      $display("[TB] frame %0d keys=%h valid=%b code=%0d held=%b", frame_no, mask, key_valid, key_code, key_held);
      frame_no++;
   endtask

   task automatic test_reset();
      logic [3:0] one4;
      logic [3:0] exp_col;
      one4    = 4'b0001;
      rstn    = 1'b0;
      scan_en = 1'b0;
      keys    = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({col_out, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got col %b valid %b code %0d held %b want 1110 0 0 0",
                  col_out, key_valid, key_code, key_held);
      end
      rstn = 1'b1;
      // Eight strobes (two full NONE frames) keep the column aligned for later tests.
      for (int i = 0; i < 8; i++) begin
         repeat (3) @(posedge clk);
         #1;
         scan_en = 1'b1;
         @(posedge clk); #1;
         scan_en = 1'b0;
         exp_col = ~(one4 << ((i + 1) % 4));
         n_tests++;
         if (col_out !== exp_col || key_valid !== 1'b0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_scan step %0d: got col %b valid %b held %b want col %b valid 0 held 0",
                     i, col_out, key_valid, key_held, exp_col);
         end
         $display("[TB] reset strobe %0d col_out=%b", i, col_out);
         if (i == 3 || i == 7) model_frame(16'h0000);
      end
   endtask

   task automatic test_single_press();
      pulses_seen = 0;
      for (int i = 0; i < 5; i++) run_frame(16'h0200);
      n_tests++;
      if (pulses_seen !== 1) begin
         n_fail++;
         $display("FAIL single_press_count: got %0d pulses want 1", pulses_seen);
      end
   endtask

   task automatic test_release();
      pulses_seen = 0;
      for (int i = 0; i < 4; i++) run_frame(16'h0000);
      n_tests++;
      if (pulses_seen !== 0 || key_held !== 1'b0) begin
         n_fail++;
         $display("FAIL release: got %0d pulses held %b want 0 pulses held 0", pulses_seen, key_held);
      end
   endtask

   task automatic test_bounce();
      logic [15:0] seq [6];
      seq = '{16'h0200, 16'h0200, 16'h0000, 16'h0200, 16'h0200, 16'h0200};
      pulses_seen = 0;
      for (int i = 0; i < 6; i++) run_frame(seq[i]);
      n_tests++;
      if (pulses_seen !== 1) begin
         n_fail++;
         $display("FAIL bounce_count: got %0d pulses want 1", pulses_seen);
      end
   endtask

   task automatic test_multi();
      // roll-over to key 5, then keys 0 and 7 together, release, press 9
      for (int i = 0; i < 3; i++) run_frame(16'h0020);
      pulses_seen = 0;
      for (int i = 0; i < 4; i++) run_frame(16'h0081);
      n_tests++;
      if (pulses_seen !== 0 || key_code !== 4'd5 || key_held !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_hold: got %0d pulses code %0d held %b want 0 pulses code 5 held 1",
                  pulses_seen, key_code, key_held);
      end
      for (int i = 0; i < 3; i++) run_frame(16'h0000);
      for (int i = 0; i < 3; i++) run_frame(16'h0200);
   endtask

   task automatic test_reset_mid();
      int stray;
      run_frame(16'h0200);
      keys = 16'h0200;
      for (int c = 0; c < 2; c++) begin
         repeat (3) @(posedge clk);
         #1;
         scan_en = 1'b1;
         @(posedge clk); #1;
         scan_en = 1'b0;
      end
      rstn = 1'b0;
      #2;
      n_tests++;
      if ({col_out, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid: got col %b valid %b code %0d held %b want 1110 0 0 0",
                  col_out, key_valid, key_code, key_held);
      end
      @(posedge clk); #1;
      keys = '0;
      rstn = 1'b1;
      model_reset();
      stray = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (key_valid) stray++;
      end
      n_tests++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL reset_release_pulse: got %0d pulses want 0", stray);
      end
      $display("[TB] reset mid-debounce done");
      for (int i = 0; i < 4; i++) run_frame(16'h0200);
   endtask

   task automatic test_random();
      logic [15:0] one16;
      logic [15:0] mask;
      int          kind, k1, k2, len;
      one16 = 16'h0001;
      for (int g = 0; g < 18; g++) begin
         kind = $urandom_range(0, 4);
         k1   = $urandom_range(0, 15);
         k2   = (k1 + 1 + $urandom_range(0, 14)) % 16;
         if (kind == 0) mask = '0;
         else if (kind == 4) mask = (one16 << k1) | (one16 << k2);
         else mask = one16 << k1;
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) run_frame(mask);
      end
   endtask

`ifdef KEYPAD_REPEAT_EN
   task automatic test_repeat();
      for (int i = 0; i < 3; i++) run_frame(16'h0000);
      for (int i = 0; i < 3; i++) run_frame(16'h0200);
      pulses_seen = 0;
      for (int i = 0; i < 30; i++) run_frame(16'h0200);
      n_tests++;
      if (pulses_seen !== 3 || key_code !== 4'd9) begin
         n_fail++;
         $display("FAIL repeat_count: got %0d pulses code %0d want 3 pulses code 9", pulses_seen, key_code);
      end
   endtask
`endif

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      frame_no    = 0;
      pulses_seen = 0;
      rstn        = 1'b0;
      scan_en     = 1'b0;
      keys        = '0;
      test_reset();
      test_single_press();
      test_release();
      test_bounce();
      test_multi();
      test_reset_mid();
      test_random();
`ifdef KEYPAD_REPEAT_EN
      test_repeat();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanned 4x4 matrix keypad reader; input-side counterpart of the multiplexed 7-segment display driver. Drives one active-low column at a time, samples the active-low rows, debounces whole scan frames, and reports single key presses as a one-cycle event plus code. Sits between the board keypad pins and the game control logic; column stepping is paced by a prescaler tick, typically the 1 kHz enable.

## Interface
- DEBOUNCE, 3: consecutive identical frames required before a press or release is accepted (1..15).
- REPEAT_FRAMES, 8: frames between auto-repeat events; used only with KEYPAD_REPEAT_EN.
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- scan_en  in  1  single-cycle column-step strobe; minimum spacing 3 clk.
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  out  4  column drive, active-low one-hot.
- key_valid  out  1  one-cycle pulse: accepted press (or repeat).
- key_code  out  4  row*4+col of the last accepted key; held between events.
- key_held  out  1  high while an accepted key remains stably pressed.

## Operation
- row_in passes through a 2-FF synchronizer before any use.
- Column counter col 0..3; col_out = ~(1<<col). On scan_en: latch synced rows for current col, then col <= col+1, wrapping 3->0.
- A scan_en at col==3 completes a frame. Frame result is NONE (no row low in any column), SINGLE(code) (exactly one row/col intersection low), or MULTI (two or more).
- Debounce: candidate register plus 4-bit counter saturating at DEBOUNCE. MULTI frame: counter cleared, candidate cleared, FSM state unchanged. Frame equal to candidate: counter++. Different frame: candidate <= frame, counter <= 1.
- FSM states IDLE, HELD.
  - IDLE: counter reaches DEBOUNCE on SINGLE(c) -> key_valid pulse, key_code <= c, key_held <= 1, go HELD.
  - HELD: counter reaches DEBOUNCE on NONE -> key_held <= 0, go IDLE, no pulse.
  - HELD: counter reaches DEBOUNCE on SINGLE(c') with c' != key_code (roll-over) -> key_valid pulse, key_code <= c', stay HELD.
- Acceptance fires once per transition to DEBOUNCE, never again while saturated.
- Reset values: col_out=4'b1110, key_valid=0, key_code=0, key_held=0, state IDLE, counter 0, candidate NONE, synchronizer flops 1111.
- rstn asserted mid-frame or mid-debounce: all state returns to reset values immediately; no pulse is emitted on release of rstn.

## Timing
- Frame = 4 scan_en strobes. Column drive settles for one full scan_en period before its rows are sampled.
- Frame completes at edge E (scan_en, col 3); frame result registered at E. Debounce/FSM update at E+1; key_valid high for exactly the cycle after E+1, with key_code already valid in that cycle.
- Press-to-key_valid latency: DEBOUNCE frames after the first clean frame, plus 2 clk, plus synchronizer delay.
- scan_en arriving while key_valid is high has no effect on the pulse.

## Configuration
- KEYPAD_REPEAT_EN defined: 8-bit repeat frame counter, cleared on every acceptance. While HELD with stable matching frames, key_valid re-pulses with the same key_code every REPEAT_FRAMES completed frames.
- Undefined: no repeat counter; exactly one key_valid per accepted press.

## Structure
- Shared package keypad_pkg: NUM_ROWS=4, NUM_COLS=4, CODE_W=4, frame-result enum (NONE, SINGLE, MULTI), FSM state enum (IDLE, HELD).
- One sub-module, keypad_debounce: candidate/counter/FSM and repeat logic. Scanner, synchronizer, and frame classification stay in keypad_scan.

## Test plan
- Reset, then 5 scan_en strobes: col_out 1110 -> 1101 -> 1011 -> 0111 -> 1110 -> 1101; all outputs 0.
- Key row 2/col 1 held, DEBOUNCE=3: exactly one key_valid, 2 clk after 3rd frame end; key_code=9, key_held=1.
- Bounce: key 9 present 2 frames, absent 1, present 3 -> single key_valid after the final 3-frame run only.
- Keys row0/col0 and row1/col3 together -> no key_valid; key_held and key_code unchanged; release then press 9 -> normal acceptance.
- Key 9 held, then released 3 frames -> key_held falls 2 clk after 3rd NONE frame, no pulse; rstn pulsed mid-debounce -> reset values, no pulse.
- KEYPAD_REPEAT_EN, REPEAT_FRAMES=8, key 9 held 30 frames after acceptance -> 3 extra key_valid pulses, 8 frames apart, key_code=9.
